// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS Avalon-MM bus: arbiter state encoding and slave response codes.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/mips_avalon_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter with sticky bus-error and stall-timeout flags.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic [1:0]          s_response,
  output logic [1:0]          grant,
  output logic                bus_error,
  output logic                timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state, state_next;
  logic             m0_req, m1_req;
  logic             pick1;
  logic             grant_start;
  logic             completing;
  logic [CNT_W-1:0] stall_cnt;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // On a tie the master that was not granted last wins.
  assign pick1 = m1_req & (~m0_req | ~last_owner);

  always_ff @(posedge clk) begin
    if (reset)
      last_owner <= 1'b0;
    else if (grant_start)
      last_owner <= pick1;
  end
`else
  assign pick1 = m1_req & ~m0_req;
`endif

  assign grant_start = (state == IDLE) && (m0_req || m1_req);
  assign completing  = (s_read | s_write) & ~s_waitrequest;
  assign grant       = {state == OWN1, state == OWN0};

  // An owner returns to IDLE on completion or when it drops its request (abort).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (m0_req || m1_req) state_next = pick1 ? OWN1 : OWN0;
      OWN0:    if (!m0_req || completing) state_next = IDLE;
      OWN1:    if (!m1_req || completing) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read and write both high is treated as a write, so the read strobe is masked.
  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    case (state)
      OWN0: begin
        s_address      = m0_address;
        s_byteenable   = m0_byteenable;
        s_read         = m0_read & ~m0_write;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
      OWN1: begin
        s_address      = m1_address;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read & ~m1_write;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      bus_error <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_start) begin
        stall_cnt <= '0;
      end else if (state != IDLE && s_waitrequest && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
        if (stall_cnt == CNT_MAX - CNT_ONE)
          timeout <= 1'b1;
      end
      if (completing && s_response != RESP_OKAY)
        bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter; the slave side is driven directly by the bench.
module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, s_address;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;
  logic [1:0]  grant;
  logic        bus_error, timeout;

  int ntests = 0;
  int nfail  = 0;
  logic rr_last = 1'b0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_response(s_response),
    .grant(grant), .bus_error(bus_error), .timeout(timeout)
  );

  // Advance one clock; everything afterwards happens 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
    s_waitrequest = 1'b1; s_readdata = '0; s_response = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
    ntests++; if (grant !== 2'b00) begin nfail++; $display("[TB] FAIL reset_grant got %b want 00", grant); end
    ntests++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      nfail++; $display("[TB] FAIL reset_wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    ntests++; if (s_read !== 1'b0 || s_write !== 1'b0) begin
      nfail++; $display("[TB] FAIL reset_strobes got rd=%b wr=%b want 0 0", s_read, s_write); end
    ntests++; if (bus_error !== 1'b0 || timeout !== 1'b0) begin
      nfail++; $display("[TB] FAIL reset_flags got err=%b to=%b want 0 0", bus_error, timeout); end
  endtask

  task automatic test_single_read();
    m0_read = 1'b1; m0_address = 32'hBFC00000; m0_byteenable = 4'hF;
    s_waitrequest = 1'b1;
    ntests++; if (grant !== 2'b00 || s_read !== 1'b0) begin
      nfail++; $display("[TB] FAIL rd_cycleN got grant=%b s_read=%b want 00 0", grant, s_read); end
    tick();
    ntests++; if (grant !== 2'b01) begin nfail++; $display("[TB] FAIL rd_grant got %b want 01", grant); end
    ntests++; if (s_read !== 1'b1 || s_address !== 32'hBFC00000 || s_byteenable !== 4'hF) begin
      nfail++; $display("[TB] FAIL rd_slave got rd=%b addr=%h be=%h want 1 bfc00000 f", s_read, s_address, s_byteenable); end
    ntests++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      nfail++; $display("[TB] FAIL rd_stall_wait got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    tick();
    ntests++; if (grant !== 2'b01) begin nfail++; $display("[TB] FAIL rd_hold got %b want 01", grant); end
    tick();
    s_waitrequest = 1'b0; s_readdata = 32'h24020005;
    #1;
    ntests++; if (m0_waitrequest !== 1'b0 || m0_readdata !== 32'h24020005) begin
      nfail++; $display("[TB] FAIL rd_data got wait=%b data=%h want 0 24020005", m0_waitrequest, m0_readdata); end
    ntests++; if (m1_readdata !== 32'h0) begin nfail++; $display("[TB] FAIL rd_other got %h want 0", m1_readdata); end
    tick();
    idle_inputs();
    ntests++; if (grant !== 2'b00 || s_read !== 1'b0) begin
      nfail++; $display("[TB] FAIL rd_release got grant=%b s_read=%b want 00 0", grant, s_read); end
    rr_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    m0_read = 1'b1; m0_address = 32'h00000100; m0_byteenable = 4'hF;
    m1_read = 1'b1; m1_address = 32'h00000200; m1_byteenable = 4'h3;
    s_waitrequest = 1'b0; s_readdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp = rr_last ? 2'b01 : 2'b10;
`else
      exp = 2'b01;
`endif
      rr_last = exp[1];
      tick();
      ntests++; if (grant !== exp) begin
        nfail++; $display("[TB] FAIL tie_grant[%0d] got %b want %b", i, grant, exp); end
      ntests++; if (s_address !== (exp[1] ? 32'h00000200 : 32'h00000100)) begin
        nfail++; $display("[TB] FAIL tie_addr[%0d] got %h", i, s_address); end
      ntests++; if (m0_waitrequest !== exp[1] || m1_waitrequest !== exp[0]) begin
        nfail++; $display("[TB] FAIL tie_wait[%0d] got %b%b want %b%b", i, m0_waitrequest, m1_waitrequest, exp[1], exp[0]); end
      tick();
      ntests++; if (grant !== 2'b00) begin nfail++; $display("[TB] FAIL tie_gap[%0d] got %b want 00", i, grant); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_decode_error();
    m1_write = 1'b1; m1_address = 32'h10000000; m1_byteenable = 4'hF; m1_writedata = 32'hDEADBEEF;
    s_waitrequest = 1'b0; s_response = 2'b11;
    tick();
    ntests++; if (grant !== 2'b10 || s_write !== 1'b1 || s_writedata !== 32'hDEADBEEF) begin
      nfail++; $display("[TB] FAIL err_xfer got grant=%b wr=%b data=%h want 10 1 deadbeef", grant, s_write, s_writedata); end
    ntests++; if (bus_error !== 1'b0) begin nfail++; $display("[TB] FAIL err_early got %b want 0", bus_error); end
    tick();
    idle_inputs();
    ntests++; if (bus_error !== 1'b1 || grant !== 2'b00) begin
      nfail++; $display("[TB] FAIL err_set got err=%b grant=%b want 1 00", bus_error, grant); end
    // A clean transfer afterwards must not clear the sticky flag.
    m0_write = 1'b1; m0_address = 32'h00000040; m0_writedata = 32'h1; s_waitrequest = 1'b0;
    tick();
    tick();
    idle_inputs();
    tick();
    ntests++; if (bus_error !== 1'b1) begin nfail++; $display("[TB] FAIL err_sticky got %b want 1", bus_error); end
    rr_last = 1'b0;
  endtask

  task automatic test_timeout();
    m0_write = 1'b1; m0_address = 32'h00000080; m0_writedata = 32'hCAFEF00D; m0_byteenable = 4'hF;
    s_waitrequest = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    ntests++; if (timeout !== 1'b0) begin nfail++; $display("[TB] FAIL to_early got %b want 0", timeout); end
    tick();
    ntests++; if (timeout !== 1'b1) begin nfail++; $display("[TB] FAIL to_set got %b want 1", timeout); end
    ntests++; if (grant !== 2'b01 || m0_waitrequest !== 1'b1) begin
      nfail++; $display("[TB] FAIL to_hold got grant=%b wait=%b want 01 1", grant, m0_waitrequest); end
    m0_write = 1'b0;
    tick();
    ntests++; if (grant !== 2'b00 || timeout !== 1'b1) begin
      nfail++; $display("[TB] FAIL to_abort got grant=%b to=%b want 00 1", grant, timeout); end
    ntests++; if (bus_error !== 1'b1) begin nfail++; $display("[TB] FAIL abort_err got %b want 1", bus_error); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    m1_write = 1'b1; m1_address = 32'h00000300; m1_writedata = 32'h55AA55AA; m1_byteenable = 4'hF;
    s_waitrequest = 1'b1;
    tick();
    tick();
    ntests++; if (grant !== 2'b10 || s_write !== 1'b1) begin
      nfail++; $display("[TB] FAIL mid_own got grant=%b wr=%b want 10 1", grant, s_write); end
    reset = 1'b1;
    tick();
    ntests++; if (grant !== 2'b00 || s_write !== 1'b0) begin
      nfail++; $display("[TB] FAIL mid_reset got grant=%b wr=%b want 00 0", grant, s_write); end
    ntests++; if (timeout !== 1'b0 || bus_error !== 1'b0 || m1_waitrequest !== 1'b1) begin
      nfail++; $display("[TB] FAIL mid_flags got to=%b err=%b wait=%b want 0 0 1", timeout, bus_error, m1_waitrequest); end
    reset = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_decode_error();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
